iter_alu_cc: RTL

//  Multi-cycle, parametrised integer ALU for the SEQ/PIPE execute stage. Supports Y86 OPq: ADD, SUB, AND, XOR.

---
 rtl/iter_alu_cc_pkg.sv | 23 ++
 rtl/iter_alu_cc_rca_slice.sv | 45 ++++
 rtl/iter_alu_cc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/iter_alu_cc_pkg.sv
// Shared ALU definitions: op encodings, FSM states, condition-code bit positions.
// No logic, so there is no latency.
// No handshake; the encodings are consumed by iter_alu_cc and rca_slice.
package iter_alu_cc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

endpackage

// File: rtl/iter_alu_cc_rca_slice.sv
// One SLICE-bit ripple-carry adder/subtractor with an AND/XOR bypass.
// Combinational; no latency.
// No handshake; the owning FSM decides when the outputs are used.
module rca_slice
  import iter_alu_cc_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic             arith;
  logic [SLICE-1:0] bb;
  logic [SLICE-1:0] sum;
  logic [SLICE:0]   c;

  assign arith = (op == OP_ADD) || (op == OP_SUB);
  assign bb    = (op == OP_SUB) ? ~b : b;
  assign c[0]  = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]  = a[i] ^ bb[i] ^ c[i];
    assign c[i+1]  = (a[i] & bb[i]) | (c[i] & (a[i] ^ bb[i]));
  end

  always_comb begin
    s = sum;
    case (op)
      OP_AND:  s = a & b;
      OP_XOR:  s = a ^ b;
      default: s = sum;
    endcase
  end

  // Logic ops report no carry so the captured flags are zero for them.
  assign cout     = arith ? c[SLICE]   : 1'b0;
  assign c_msb_in = arith ? c[SLICE-1] : 1'b0;

endmodule

// File: rtl/iter_alu_cc.sv
// Iterative ADD/SUB/AND/XOR ALU, SLICE bits per cycle; optional cc register via ALU_CC_REG_EN.
// Latency: out_valid rises NSLICE cycles after the accept edge.
// Backpressure: result and flags held in DONE until out_ready; in_ready only in IDLE.
module iter_alu_cc
  import iter_alu_cc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carryout,
  output logic             ovf,
  output logic             zf,
  output logic             sf
`ifdef ALU_CC_REG_EN
  ,
  output logic [2:0]       cc
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  alu_state_e       state, state_n;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic [CNT_W-1:0] idx;
  logic             carry_q;
  logic             accept, last;
  logic [SLICE-1:0] s;
  logic             s_cout, s_cmsb;

  assign last = (idx == CNT_W'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: if (last) state_n = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  rca_slice #(.SLICE(SLICE)) u_slice (
    .a        (a_q[SLICE-1:0]),
    .b        (b_q[SLICE-1:0]),
    .cin      (carry_q),
    .op       (op_q),
    .s        (s),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  // Operands shift down one slice per cycle; results shift in from the top,
  // so after NSLICE cycles slice i of y sits at bits [i*SLICE +: SLICE].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      idx      <= '0;
      carry_q  <= 1'b0;
      carryout <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      op_q    <= alu_op_e'(op);
      a_q     <= a;
      b_q     <= b;
      idx     <= '0;
      carry_q <= (op == OP_SUB);
    end else if (state == ST_BUSY) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      y_q     <= (y_q >> SLICE) | (WIDTH'(s) << (WIDTH - SLICE));
      carry_q <= s_cout;
      idx     <= idx + 1'b1;
      if (last) begin
        carryout <= s_cout;
        ovf      <= s_cout ^ s_cmsb;
      end
    end
  end

  assign y  = y_q;
  assign zf = (y_q == '0);
  assign sf = y_q[WIDTH-1];

`ifdef ALU_CC_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= 3'b100;
    end else if (out_valid && out_ready) begin
      cc[CC_ZF] <= zf;
      cc[CC_SF] <= sf;
      cc[CC_OF] <= ovf;
    end
  end
`endif

endmodule
